// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions for the decryptor and the encryption pipeline.
// Contents: FSM state enum, byte-order constants, Rcon table, GF(2^8) helpers
// (xtime, gf_mul, gf_inv), SBOX / INV_SBOX and the forward/inverse key steps.
// Byte order: byte i of a 128-bit block sits at [BYTE0_MSB-8*i -: 8], where
// i = 4*column + row (column-major, byte 0 in the top bits).
package aes128_pkg;

  typedef enum logic [1:0] {IDLE, EXPAND, ROUNDS, DONE} state_t;

  localparam int BLOCK_W   = 128;
  localparam int NUM_BYTES = 16;
  localparam int BYTE0_MSB = BLOCK_W - 1;

  function automatic int byte_msb(input int i);
    return BYTE0_MSB - 8 * i;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254: six square-and-multiply steps reach
  // a^127, one more squaring gives a^254. Zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  // SubWord(RotWord(w)) ^ {rc, 0, 0, 0}
  function automatic logic [31:0] key_core(input logic [31:0] w, input logic [7:0] rc);
    return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  // K(r-1) -> K(r) using Rcon[r]
  function automatic logic [127:0] key_expand_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ key_core(k[31:0], rc);
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // K(r) -> K(r-1) using Rcon[r]
  function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ key_core(w3, rc);
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when last).
// Ports: state (round input), round_key, last (final round select), result.
module aes_inv_round
  import aes128_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] result
);

  logic [127:0] keyed;
  logic [127:0] mixed;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // Row r rotates right by r: output column c takes input column (c-r) mod 4.
  always_comb begin
    keyed = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        keyed[byte_msb(4*c + r) -: 8] =
          inv_sbox(state[byte_msb(4*((c - r + 4) % 4) + r) -: 8]) ^ round_key[byte_msb(4*c + r) -: 8];
      end
    end
  end

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[byte_msb(4*c) -: 32] = inv_mix_col(keyed[byte_msb(4*c) -: 32]);
    end
  end

  assign result = last ? keyed : mixed;

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryptor, one round per clock, round keys on the fly.
// EXPAND walks the forward schedule from K0 to K10, ROUNDS walks it back.
// Ports: clk, rst_n (async, active-low), IN_VALID/IN_READY/IN_DATA/IN_KEY
// (ciphertext + key in), OUT_VALID/OUT_READY/OUT_DATA (plaintext out).
// Optional feature macro: DEC_KEY_CACHE_EN keeps K10 of the last expanded
// key so a repeated key skips EXPAND.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// IN_READY is high exactly in IDLE and does not depend on IN_VALID.
// OUT_VALID, once high, stays high with OUT_DATA frozen until OUT_READY.
module aes128_decrypt_iter
  import aes128_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [127:0] IN_DATA,
  input  logic [127:0] IN_KEY,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [127:0] OUT_DATA
);

  state_t       state, state_next;
  logic [3:0]   cnt;
  logic [127:0] data_reg, key_reg, out_data_reg;
  logic         out_valid_reg;
  logic [127:0] next_key, prev_key, round_out;
  logic         accept, cache_hit;

`ifdef DEC_KEY_CACHE_EN
  // k0_reg only feeds the cache compare, so it exists only with the cache.
  logic [127:0] k0_reg, k10_reg;
  logic         cache_valid;
  assign cache_hit = cache_valid && (IN_KEY == k0_reg);
`else
  assign cache_hit = 1'b0;
`endif

  assign accept   = IN_VALID && IN_READY;
  assign next_key = key_expand_step(key_reg, rcon(cnt));
  assign prev_key = inv_key_step(key_reg, rcon(cnt));

  aes_inv_round u_round (
    .state     (data_reg),
    .round_key (prev_key),
    .last      (cnt == 4'd1),
    .result    (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = cache_hit ? ROUNDS : EXPAND;
      EXPAND:  if (cnt == 4'd10) state_next = ROUNDS;
      ROUNDS:  if (cnt == 4'd1) state_next = DONE;
      DONE:    if (OUT_READY) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    IN_READY = (state == IDLE);
  end

  assign OUT_VALID = out_valid_reg;
  assign OUT_DATA  = out_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      data_reg      <= '0;
      key_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
`ifdef DEC_KEY_CACHE_EN
      k0_reg        <= '0;
      k10_reg       <= '0;
      cache_valid   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
`ifdef DEC_KEY_CACHE_EN
          k0_reg <= IN_KEY;
`endif
          if (cache_hit) begin
`ifdef DEC_KEY_CACHE_EN
            // Skip EXPAND: start from the cached K10 with the first AddRoundKey folded in.
            key_reg  <= k10_reg;
            data_reg <= IN_DATA ^ k10_reg;
`endif
            cnt <= 4'd10;
          end else begin
            key_reg  <= IN_KEY;
            data_reg <= IN_DATA;
            cnt      <= 4'd1;
          end
        end
        EXPAND: begin
          key_reg <= next_key;
          if (cnt == 4'd10) begin
            // next_key is K10 here; cnt stays 10 to start ROUNDS.
            data_reg <= data_reg ^ next_key;
`ifdef DEC_KEY_CACHE_EN
            k10_reg     <= next_key;
            cache_valid <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ROUNDS: begin
          data_reg <= round_out;
          key_reg  <= prev_key;
          cnt      <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            out_data_reg  <= round_out;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: if (OUT_READY) out_valid_reg <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Testbench for aes128_decrypt_iter: FIPS-197 vectors, backpressure, reset
// mid-ROUNDS, key-cache latency and an encrypt->decrypt loopback against a
// byte-array AES model built from a generated S-box table.
module tb_aes128_decrypt_iter;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [127:0] IN_DATA = '0;
  logic [127:0] IN_KEY = '0;
  logic         OUT_VALID;
  logic         OUT_READY = 1'b1;
  logic [127:0] OUT_DATA;

  always #5 clk = ~clk;

  aes128_decrypt_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .IN_KEY    (IN_KEY),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA)
  );

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   sb[256];
  logic [7:0]   isb[256];
  bit           cache_ok = 1'b0;
  logic [127:0] cache_key = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] bt(input logic [127:0] s, input int i);
    return s[127 - 8*i -: 8];
  endfunction

  // Round key r from the full 44-word FIPS-197 schedule.
  function automatic logic [127:0] rk(input logic [127:0] key, input int r);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127 - 8*(4*c + r) -: 8] = inv ? isb[bt(s, 4*src + r)] : sb[bt(s, 4*src + r)];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    logic [7:0]   cf[4];
    logic [7:0]   v;
    o = '0;
    if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
    else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        v = 8'h00;
        for (int j = 0; j < 4; j++) v = v ^ gm(bt(s, 4*c + j), cf[(j - r + 4) % 4]);
        o[127 - 8*(4*c + r) -: 8] = v;
      end
    return o;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s;
    s = pt ^ rk(key, 0);
    for (int r = 1; r <= 10; r++) begin
      s = sub_shift(s, 1'b0);
      if (r < 10) s = mix(s, 1'b0);
      s = s ^ rk(key, r);
    end
    return s;
  endfunction

  function automatic logic [127:0] dec(input logic [127:0] ct, input logic [127:0] key);
    logic [127:0] s;
    s = ct ^ rk(key, 10);
    for (int r = 9; r >= 0; r--) begin
      s = sub_shift(s, 1'b1) ^ rk(key, r);
      if (r > 0) s = mix(s, 1'b1);
    end
    return s;
  endfunction

  // S-box by walking the multiplicative group with generator 3.
  task automatic build_sbox;
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = i[7:0];
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (rst_n && OUT_VALID) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out_valid: got OUT_VALID=1 with no pending block, want 0");
      end else begin
        check("out_data", OUT_DATA, exp_q[0]);
        if (OUT_READY) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic accept(input logic [127:0] d, input logic [127:0] k);
    int w;
    w = 0;
    IN_DATA  = d;
    IN_KEY   = k;
    IN_VALID = 1'b1;
    while (!IN_READY && w < 100) begin
      tick;
      w++;
    end
    if (!IN_READY) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got IN_READY=0 want 1");
    end
    tick;
    IN_VALID = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [127:0] ct, input logic [127:0] key,
                         input logic [127:0] pt);
    int lat_exp;
    int k;
    bit hit;
`ifdef DEC_KEY_CACHE_EN
    hit = cache_ok && (key == cache_key);
`else
    hit = 1'b0;
`endif
    lat_exp = hit ? 10 : 20;
    exp_q.push_back(pt);
    accept(ct, key);
    k = 0;
    do begin
      tick;
      k++;
    end while (!OUT_VALID && k <= 40);
    check({name, "_latency"}, k, lat_exp);
    cache_ok  = 1'b1;
    cache_key = key;
    if (OUT_READY) begin
      tick;
      check({name, "_out_valid_drop"}, OUT_VALID, 0);
      check({name, "_in_ready_back"}, IN_READY, 1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] key, pt;
    int cnt_v;
    build_sbox;
    check("model_sbox_01", sb[8'h01], 8'h7c);
    check("model_sbox_53", sb[8'h53], 8'hed);
    check("model_isbox_00", isb[8'h00], 8'h52);
    check("model_dec_c1", dec(C1_CT, C1_KEY), C1_PT);
    check("model_enc_b", enc(B_PT, B_KEY), B_CT);

    #1;
    check("reset_in_ready", IN_READY, 1);
    check("reset_out_valid", OUT_VALID, 0);
    check("reset_out_data", OUT_DATA, 0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;

    run_one("c1_first", C1_CT, C1_KEY, C1_PT);
    run_one("c1_repeat", C1_CT, C1_KEY, C1_PT);

    // Backpressure: result held 15 cycles, a second request must be ignored.
    OUT_READY = 1'b0;
    run_one("b_held", B_CT, B_KEY, B_PT);
    for (int i = 0; i < 15; i++) begin
      if (i == 3) begin IN_VALID = 1'b1; IN_DATA = C1_CT; IN_KEY = C1_KEY; end
      if (i == 6) IN_VALID = 1'b0;
      tick;
      check("bp_in_ready_low", IN_READY, 0);
      check("bp_out_valid_held", OUT_VALID, 1);
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    tick;
    check("bp_release_out_valid", OUT_VALID, 0);
    check("bp_release_in_ready", IN_READY, 1);
    cnt_v = 0;
    for (int i = 0; i < 25; i++) begin
      tick;
      if (OUT_VALID || !IN_READY) cnt_v++;
    end
    check("bp_no_second_accept", cnt_v, 0);

    // Reset at t14, in the middle of ROUNDS.
    accept(C1_CT, C1_KEY);
    for (int i = 0; i < 14; i++) tick;
    rst_n = 1'b0;
    exp_q.delete();
    cache_ok = 1'b0;
    #1;
    check("midreset_in_ready", IN_READY, 1);
    check("midreset_out_valid", OUT_VALID, 0);
    check("midreset_out_data", OUT_DATA, 0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;

    run_one("c1_after_reset", C1_CT, C1_KEY, C1_PT);
    run_one("c1_cache", C1_CT, C1_KEY, C1_PT);
    run_one("b_new_key", B_CT, B_KEY, B_PT);

    // Loopback: model-encrypted random plaintexts, keys reused in groups of 4.
    key = '0;
    for (int v = 0; v < 1000; v++) begin
      if (v % 4 == 0) key = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      run_one("loopback", enc(pt, key), key, pt);
    end

    tick;
    tick;
    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3ms;
    n_bad++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
